// File: rtl/move_controller.sv
// Tic-tac-toe cursor/turn controller: turns cursor and place pulses into single-cycle grid writes.
// Build option MOVE_CONTROLLER_WRAP_EN makes cursor moves wrap at the board edges instead of saturating.
module move_controller #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] dir,
  input  logic       move_valid,
  input  logic       place,
  input  logic       clear,
  output logic [3:0] cursor,
  output logic [3:0] select,
  output logic [1:0] value,
  output logic       load,
  output logic       reject,
  output logic       turn,
  output logic       busy,
  output logic       board_full
);

  // state  | meaning
  // IDLE   | accept cursor moves and place requests
  // CHECK  | test the latched cell against occupancy and the full flag
  // WRITE  | load strobe out; commit occupancy and toggle turn on exit
  // REJECT | reject strobe out; nothing changes
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_REJECT = 2'd3;

`ifdef MOVE_CONTROLLER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic [3:0] cursor_q, cursor_d;
  logic [3:0] select_q, select_d;
  logic [1:0] value_q, value_d;
  logic       load_q, load_d;
  logic       reject_q, reject_d;
  logic       turn_q, turn_d;
  logic       busy_q, busy_d;
  logic       full_q, full_d;
  logic [8:0] occ_q, occ_d;
  logic [3:0] count_q, count_d;

  logic [3:0] rc;
  logic [3:0] cursor_mv;

  always_comb begin
    case (cursor_q)
      4'd0:    rc = 4'b0000;
      4'd1:    rc = 4'b0001;
      4'd2:    rc = 4'b0010;
      4'd3:    rc = 4'b0100;
      4'd4:    rc = 4'b0101;
      4'd5:    rc = 4'b0110;
      4'd6:    rc = 4'b1000;
      4'd7:    rc = 4'b1001;
      4'd8:    rc = 4'b1010;
      default: rc = 4'b0101;
    endcase
  end

  // rc[3:2] is the row, rc[1:0] the column of the current cursor.
  always_comb begin
    cursor_mv = cursor_q;
    case (dir)
      2'b00: if (rc[3:2] != 2'd0) cursor_mv = cursor_q - 4'd3;
             else if (WRAP)       cursor_mv = cursor_q + 4'd6;
      2'b01: if (rc[3:2] != 2'd2) cursor_mv = cursor_q + 4'd3;
             else if (WRAP)       cursor_mv = cursor_q - 4'd6;
      2'b10: if (rc[1:0] != 2'd2) cursor_mv = cursor_q + 4'd1;
             else if (WRAP)       cursor_mv = cursor_q - 4'd2;
      default: if (rc[1:0] != 2'd0) cursor_mv = cursor_q - 4'd1;
               else if (WRAP)       cursor_mv = cursor_q + 4'd2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    select_d = select_q;
    value_d  = value_q;
    load_d   = 1'b0;
    reject_d = 1'b0;
    turn_d   = turn_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (clear) begin
      state_d  = S_IDLE;
      cursor_d = 4'd4;
      occ_d    = '0;
      count_d  = '0;
      turn_d   = FIRST_PLAYER;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (place) begin
            select_d = cursor_q;
            state_d  = S_CHECK;
          end else if (move_valid) begin
            cursor_d = cursor_mv;
          end
        end
        S_CHECK: begin
          if (occ_q[select_q] || full_q) begin
            state_d  = S_REJECT;
            reject_d = 1'b1;
          end else begin
            state_d = S_WRITE;
            load_d  = 1'b1;
            value_d = turn_q ? 2'b10 : 2'b01;
          end
        end
        S_WRITE: begin
          occ_d[select_q] = 1'b1;
          if (count_q != 4'd9) count_d = count_q + 4'd1;
          turn_d  = ~turn_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
    full_d = (count_d == 4'd9);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cursor_q <= 4'd4;
      select_q <= 4'd0;
      value_q  <= 2'b00;
      load_q   <= 1'b0;
      reject_q <= 1'b0;
      turn_q   <= FIRST_PLAYER;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      select_q <= select_d;
      value_q  <= value_d;
      load_q   <= load_d;
      reject_q <= reject_d;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  assign cursor     = cursor_q;
  assign select     = select_q;
  assign value      = value_q;
  assign load       = load_q;
  assign reject     = reject_q;
  assign turn       = turn_q;
  assign busy       = busy_q;
  assign board_full = full_q;

endmodule

// File: doc/move_controller.md
# move_controller

Cursor-and-turn controller for the tic-tac-toe datapath. It converts cursor-direction and place requests into single-cycle grid write commands (`value`, `select`, `load`) for the grid-storage stage directly downstream. It keeps a shadow occupancy map so that it can reject moves onto filled cells, and it alternates players after each accepted move. The block sits between the input-conditioning logic (debounced, one-cycle pulses) and the grid register.

## Interface
- `FIRST_PLAYER`, default 0: player to move after reset or clear; 0 = X, 1 = O.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `resetn`  in  1  asynchronous, active-low reset.
- `dir`  in  2  cursor direction: Up 00, Down 01, Right 10, Left 11.
- `move_valid`  in  1  one-cycle pulse; move the cursor in `dir`.
- `place`  in  1  one-cycle pulse; mark the cell under the cursor.
- `clear`  in  1  synchronous new-game request.
- `cursor`  out  4  current cell index, 0–8 (index = row*3 + col, row 0 at top).
- `select`  out  4  write address to the grid stage.
- `value`  out  2  write data: 00 empty, 01 X, 10 O.
- `load`  out  1  one-cycle write strobe to the grid stage.
- `reject`  out  1  one-cycle pulse; the place request was refused.
- `turn`  out  1  player to move: 0 = X, 1 = O.
- `busy`  out  1  high in any state other than IDLE.
- `board_full`  out  1  high when the placed count equals 9.

## Operation
- Reset (`resetn` low, asynchronous):
  - state = IDLE.
  - `cursor` = 4, `select` = 0, `value` = 00.
  - `load`, `reject`, `busy`, `board_full` = 0.
  - `turn` = `FIRST_PLAYER`.
  - Occupancy cleared; placed count = 0.
- Cursor moves, accepted in IDLE only:
  - Up: −3 if row > 0.
  - Down: +3 if row < 2.
  - Right: +1 if col < 2.
  - Left: −1 if col > 0.
  - Otherwise the cursor holds (no wrap-around; see Configuration).
- FSM states: IDLE, CHECK, WRITE, REJECT.
  - IDLE, `place` = 1: latch `cursor` into `select`, go to CHECK. `place` takes priority over a simultaneous `move_valid`; that move is dropped.
  - CHECK: if occupancy[`select`] is set or `board_full` = 1, go to REJECT. Otherwise go to WRITE.
  - WRITE:
    - `load` = 1; `value` = 01 if `turn` = 0, else 10.
    - On exit: set occupancy[`select`], increment the count, toggle `turn`.
    - Next state IDLE.
  - REJECT: `reject` = 1, `turn` and occupancy unchanged; next state IDLE.
- `move_valid` and `place` are ignored while `busy` = 1; requests are not queued.
- `clear` is sampled in every state and has the highest priority:
  - Next state is IDLE.
  - Occupancy and count cleared; `turn` = `FIRST_PLAYER`; `cursor` = 4.
  - `load` and `reject` are 0 in the following cycle, so an in-flight place is aborted without a write.
- `value` holds its last written code outside WRITE. The downstream stage qualifies writes with `load` only.
- The placed count is 4 bits, range 0–9, and never exceeds 9.

## Timing
- Cursor move: `move_valid` high in cycle N (IDLE) gives the new `cursor` in cycle N+1.
- Place, accepted: `place` in cycle N → CHECK in N+1 → `load` high for exactly cycle N+2 → IDLE, with `turn` toggled, in N+3.
- Place, rejected: `reject` high for exactly cycle N+2 → IDLE in N+3.
- `busy` is high in cycles N+1 and N+2. The next place can be sampled in cycle N+3 at the earliest.
- All outputs are registered; there are no combinational input-to-output paths.
- Releasing reset mid-operation restarts cleanly in IDLE with the reset values.

## Configuration
- `MOVE_CONTROLLER_WRAP_EN`
  - Defined: cursor moves wrap within the row or column.
    - Up from row 0 goes to row 2, same column; Down from row 2 goes to row 0.
    - Right from col 2 goes to col 0, same row; Left from col 0 goes to col 2.
  - Undefined: the cursor saturates at the edges, as described in Operation.

## Test plan
- Reset, then Up, Up, Left: `cursor` goes 4 → 1 → 1 → 0. With `MOVE_CONTROLLER_WRAP_EN` defined: 4 → 1 → 7 → 6.
- Reset, then place at cell 4: `load` high for one cycle 2 cycles after `place`, with `select` = 4 and `value` = 01; `turn` becomes 1 in the next cycle.
- Place again at cell 4: `reject` pulses for one cycle 2 cycles after `place`, there is no `load`, and `turn` stays 1.
- Fill all 9 cells alternately: the `value` sequence alternates 01/10, `board_full` = 1 after the ninth load, and a tenth place gives `reject` = 1.
- Pulse `clear` in the cycle after `place` (CHECK): no `load` follows, occupancy is empty, `turn` = `FIRST_PLAYER`, `cursor` = 4.
- Assert `move_valid` together with `place`, and again during `busy`: `cursor` is unchanged and exactly one write occurs.
